// File: rtl/packet_lane_summer.sv
// packet_lane_summer: lane-wise packet summer with summary FIFO; ACCEL_BEAT_COUNT_EN puts the beat count in the top lane
module packet_lane_summer #(
  parameter int OUT_DEPTH = 4,
  parameter int LANE_W    = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         io_in_valid,
  output logic         io_in_ready,
  input  logic [511:0] io_in_bits_data,
  input  logic         io_in_bits_last,
  output logic         io_out_valid,
  input  logic         io_out_ready,
  output logic [511:0] io_out_bits_data,
  output logic         io_out_bits_last
);
  localparam int N  = 512 / LANE_W;
  localparam int AW = $clog2(OUT_DEPTH);
  logic [511:0]  r_acc;
  logic [511:0]  w_sum;
  logic [511:0]  w_push;
  logic [511:0]  r_mem [OUT_DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_in_fire;
  logic          w_out_fire;
  logic          w_push_en;
  for (genvar i = 0; i < N; i++) begin : g_lane
    assign w_sum[i*LANE_W +: LANE_W] = r_acc[i*LANE_W +: LANE_W] + io_in_bits_data[i*LANE_W +: LANE_W];
  end
  assign io_in_ready      = r_cnt != (AW+1)'(OUT_DEPTH);
  assign io_out_valid     = r_cnt != '0;
  assign io_out_bits_data = r_mem[r_rp];
  assign io_out_bits_last = 1'b1;
  assign w_in_fire        = io_in_valid && io_in_ready;
  assign w_out_fire       = io_out_valid && io_out_ready;
  assign w_push_en        = w_in_fire && io_in_bits_last;
`ifdef ACCEL_BEAT_COUNT_EN
  logic [31:0] r_beats;
  always_ff @(posedge clock) begin
    if (reset) r_beats <= '0;
    else if (w_in_fire) r_beats <= io_in_bits_last ? '0 : r_beats + 32'd1;
  end
  assign w_push = {LANE_W'(r_beats + 32'd1), w_sum[511-LANE_W:0]};
`else
  assign w_push = w_sum;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_in_fire) r_acc <= io_in_bits_last ? '0 : w_sum;
      if (w_push_en) r_wp <= r_wp + 1'b1;
      if (w_out_fire) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push_en) - (AW+1)'(w_out_fire);
    end
  end
  // storage needs no reset; only entries below r_cnt are ever visible
  always_ff @(posedge clock) begin
    if (w_push_en) r_mem[r_wp] <= w_push;
  end
endmodule

// File: tb/tb_packet_lane_summer.sv
// tb_packet_lane_summer: randomized and directed checks against a lane-array/queue reference model
module tb_packet_lane_summer;
  localparam int D = 4;
  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_data;
  logic         out_last;
  int tests = 0;
  int fails = 0;
  logic [511:0] q[$];
  int unsigned  acc[16];
  int unsigned  beats;
  always #5 clock = ~clock;
  packet_lane_summer #(.OUT_DEPTH(D), .LANE_W(32)) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(in_valid), .io_in_ready(in_ready),
    .io_in_bits_data(in_data), .io_in_bits_last(in_last),
    .io_out_valid(out_valid), .io_out_ready(out_ready),
    .io_out_bits_data(out_data), .io_out_bits_last(out_last)
  );
  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [511:0] with_cnt(input logic [511:0] v, input int unsigned n);
    logic [511:0] r;
    r = v;
`ifdef ACCEL_BEAT_COUNT_EN
    r[511:480] = n;
`endif
    return r;
  endfunction
  function automatic logic [511:0] summary(input logic [511:0] d);
    logic [511:0] s;
    for (int i = 0; i < 16; i++) s[i*32 +: 32] = acc[i] + d[i*32 +: 32];
    return with_cnt(s, beats + 1);
  endfunction
  task automatic cyc(input logic v, input logic [511:0] d, input logic l, input logic ordy, input logic rst);
    bit rdy;
    in_valid = v; in_data = d; in_last = l; out_ready = ordy; reset = rst;
    rdy = q.size() < D;
    @(posedge clock);
    if (rst) begin
      q.delete();
      acc = '{default: 0};
      beats = 0;
    end else begin
      if (ordy && q.size() != 0) void'(q.pop_front());
      if (v && rdy) begin
        if (l) begin
          q.push_back(summary(d));
          acc = '{default: 0};
          beats = 0;
        end else begin
          for (int i = 0; i < 16; i++) acc[i] += d[i*32 +: 32];
          beats++;
        end
      end
    end
    @(negedge clock);
    check("in_ready", 512'(in_ready), 512'(q.size() < D));
    check("out_valid", 512'(out_valid), 512'(q.size() != 0));
    if (q.size() != 0) begin
      check("out_data", out_data, q[0]);
      check("out_last", 512'(out_last), 512'd1);
    end
  endtask
  task automatic send(input logic [511:0] d, input logic l, input logic ordy);
    bit rdy;
    for (int n = 0; n < 50; n++) begin
      rdy = q.size() < D;
      cyc(1'b1, d, l, ordy, 1'b0);
      if (rdy) return;
    end
    check("send_timeout", 512'd0, 512'd1);
  endtask
  initial begin
    logic [511:0] d;
    in_valid = 0; in_data = '0; in_last = 0; out_ready = 0; reset = 1;
    acc = '{default: 0};
    beats = 0;
    @(negedge clock);
    cyc(0, '0, 0, 0, 1);
    cyc(0, '0, 0, 0, 1);
    check("rst_valid", 512'(out_valid), 512'd0);
    check("rst_ready", 512'(in_ready), 512'd1);
    for (int k = 0; k <= 'h16; k++) begin
      for (int b = 0; b < 4; b++) send(512'(k), b == 3, 1'b1);
      check("sum4k", out_data, with_cnt(512'(4 * k), 4));
    end
    cyc(0, '0, 0, 1, 0);
    for (int p = 0; p < 4; p++)
      for (int b = 0; b < 4; b++) send(512'(p + 1), b == 3, 1'b0);
    check("bp_ready", 512'(in_ready), 512'd0);
    repeat (3) cyc(1, 512'd9, 1, 0, 0);
    for (int p = 4; p < 6; p++)
      for (int b = 0; b < 4; b++) send(512'(p + 1), b == 3, 1'b1);
    repeat (10) cyc(0, '0, 0, 1, 0);
    check("bp_drained", 512'(out_valid), 512'd0);
    d = '0;
    d[127:96] = 32'h12345678;
    send(d, 1, 0);
    check("one_beat", out_data, with_cnt(d, 1));
    cyc(0, '0, 0, 1, 0);
    send({16{32'hFFFF_FFFF}}, 0, 0);
    send({16{32'h0000_0001}}, 1, 0);
    check("wrap", out_data, with_cnt('0, 2));
    cyc(0, '0, 0, 1, 0);
    send(512'd5, 0, 1);
    send(512'd5, 0, 1);
    cyc(0, '0, 0, 1, 1);
    check("mid_rst_valid", 512'(out_valid), 512'd0);
    for (int b = 0; b < 4; b++) send(512'd1, b == 3, 0);
    check("post_rst", out_data, with_cnt(512'd4, 4));
    cyc(0, '0, 0, 1, 0);
    check("post_rst_only", 512'(out_valid), 512'd0);
`ifdef ACCEL_BEAT_COUNT_EN
    for (int b = 0; b < 3; b++) send(512'd2, b == 2, 0);
    check("beat_cnt", out_data, {32'd3, 448'd0, 32'd6});
    cyc(0, '0, 0, 1, 0);
`endif
    repeat (3000) begin
      for (int i = 0; i < 16; i++) begin
        case ($urandom_range(0, 3))
          0: d[i*32 +: 32] = 32'hFFFF_FFFF;
          1: d[i*32 +: 32] = 32'($urandom_range(0, 15));
          default: d[i*32 +: 32] = $urandom;
        endcase
      end
      cyc($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) == 0,
          $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);
    end
    repeat (20) cyc(0, '0, 0, 1, 0);
    check("final_empty", 512'(out_valid), 512'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
